wfifo_wr_arbiter: RTL

//  Shares the single write port of the async FIFO among NREQ requesters, all in the wclk domain.

---
 rtl/wfifo_arb_pkg.sv | 27 ++
 rtl/wfifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/wfifo_wr_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wfifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package wfifo_arb_pkg;

   // Arbiter FSM: IDLE picks the next owner, BURST lets that owner write.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Widest requester vector onehot_to_idx accepts; narrower vectors are zero-extended.
   localparam int unsigned ARB_MAX_REQ = 32;

   // Index of the set bit in a one-hot vector.
   // The result is an OR of the indices of all set bits, so it is only
   // meaningful when at most one bit is set. An all-zero input returns 0.
   function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/wfifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first requester at or after rr_ptr.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] pick_onehot,
   output logic            any
);

   localparam logic [NREQ-1:0] ONE_V = NREQ'(1);

   logic [2*NREQ-1:0] req_dbl;
   logic [2*NREQ-1:0] req_shift;
   logic [NREQ-1:0]   req_rot;
   logic [NREQ-1:0]   low_rot;
   logic [2*NREQ-1:0] pick_dbl;

   // Rotate so rr_ptr lands on bit 0, isolate the lowest set bit, then rotate back.
   // rr_ptr is always below NREQ, so the doubled vectors cover every wrap.
   always_comb begin
      req_dbl     = {req, req};
      req_shift   = req_dbl >> rr_ptr;
      req_rot     = req_shift[NREQ-1:0];
      low_rot     = req_rot & (~req_rot + ONE_V);
      pick_dbl    = {low_rot, low_rot} << rr_ptr;
      pick_onehot = pick_dbl[2*NREQ-1:NREQ];
      any         = |req;
   end

endmodule

// File: rtl/wfifo_wr_arbiter.sv
// Burst-granular round-robin arbiter for the write port of the async FIFO.
// One requester owns the port for a whole burst, which keeps packets contiguous.
module wfifo_wr_arbiter
   import wfifo_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DSIZE    = 8,
   parameter int MAXBURST = 8
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ack,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata
);

   localparam int CW = $clog2(MAXBURST + 1);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_MAX  = PW'(NREQ - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   arb_state_t      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [NREQ-1:0] pick_onehot;
   logic            pick_any;
   logic [PW-1:0]   owner_idx;
   logic            owner_req;
   logic            owner_last;
   logic            accept;
   logic            burst_end;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req         (req),
      .rr_ptr      (rr_ptr_q),
      .pick_onehot (pick_onehot),
      .any         (pick_any)
   );

   // Owner view: the granted requester's valid/last, whether its word is taken, and whether the burst ends.
   always_comb begin
      owner_idx  = PW'(onehot_to_idx(ARB_MAX_REQ'(gnt_q)));
      owner_req  = |(req & gnt_q);
      owner_last = |(req_last & gnt_q);
      accept     = (state_q == BURST) && owner_req && !wfull;
      burst_end  = (state_q == BURST) &&
                   ((accept && (owner_last || (cnt_q == CNT_LAST))) || !owner_req);
   end

   // Next-state logic: grant in IDLE, count accepted words in BURST, rotate the pointer past the owner on exit.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_onehot;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_ONE;
            end
            if (burst_end) begin
               gnt_d    = '0;
               cnt_d    = '0;
               state_d  = IDLE;
               rr_ptr_d = (owner_idx == PTR_MAX) ? '0 : owner_idx + PTR_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset abandons any partial burst immediately.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Write-port drive: strobe and ack follow accept, data muxed from the one-hot owner (zero when idle).
   always_comb begin
      winc    = accept;
      req_ack = accept ? gnt_q : '0;
      gnt     = gnt_q;
      busy    = (state_q == BURST);
      wdata   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            wdata = wdata | req_data[i*DSIZE +: DSIZE];
         end
      end
   end

endmodule
